// File: rtl/data_mem_responder.sv
// Responder end of the core data interface: word-addressed data RAM plus FLAG/RESULT
// status registers behind a req/gnt/rvalid handshake with programmable wait states.
module data_mem_responder #(
    parameter int unsigned MEM_WORDS   = 256,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] FLAG_ADDR   = 32'h0000_0400,
    parameter logic [31:0] RESULT_ADDR = 32'h0000_0404
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic [31:0] mem_flag_o,
    output logic [31:0] mem_result_o
);

    localparam int unsigned AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        T_RAM,
        T_FLAG,
        T_RESULT,
        T_ERR
    } target_t;

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic          gnt;

    target_t       tgt;
    logic [29:0]   word_addr;
    logic [AW-1:0] ram_idx;

    logic [31:0]   flag_reg, result_reg;
    logic [31:0]   flag_merged, result_merged;

    logic          resp_we_reg;
    target_t       resp_tgt_reg;
    logic [31:0]   resp_reg_data_reg;

    logic [31:0]   ram_mem [MEM_WORDS];
    logic [31:0]   ram_rdata_reg;

    // Byte offset bits carry no information for a word-addressed target.
    logic          unused_addr_bits;
    assign unused_addr_bits = ^data_addr_i[1:0];

    assign word_addr = data_addr_i[31:2];
    assign ram_idx   = data_addr_i[AW+1:2];

    always_comb begin
        tgt = T_ERR;
        if (word_addr < 30'(MEM_WORDS)) begin
            tgt = T_RAM;
        end else if (word_addr == FLAG_ADDR[31:2]) begin
            tgt = T_FLAG;
        end else if (word_addr == RESULT_ADDR[31:2]) begin
            tgt = T_RESULT;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign flag_merged[8*gi +: 8]   = data_be_i[gi] ? data_wdata_i[8*gi +: 8]
                                                            : flag_reg[8*gi +: 8];
            assign result_merged[8*gi +: 8] = data_be_i[gi] ? data_wdata_i[8*gi +: 8]
                                                            : result_reg[8*gi +: 8];
        end
    endgenerate

    // Handshake FSM: gnt is only ever raised in IDLE (zero wait) or on the last WAIT cycle.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        gnt        = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (data_req_i) begin
                    if (WAIT_CYCLES == 0) begin
                        gnt        = 1'b1;
                        state_next = S_RESP;
                    end else begin
                        cnt_next   = 4'(WAIT_CYCLES);
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!data_req_i) begin
                    cnt_next   = 4'd0;
                    state_next = S_IDLE;
                end else if (cnt_reg == 4'd1) begin
                    gnt        = 1'b1;
                    cnt_next   = 4'd0;
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg         <= S_IDLE;
            cnt_reg           <= 4'd0;
            flag_reg          <= 32'd0;
            result_reg        <= 32'd0;
            resp_we_reg       <= 1'b0;
            resp_tgt_reg      <= T_RAM;
            resp_reg_data_reg <= 32'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (gnt) begin
                resp_we_reg       <= data_we_i;
                resp_tgt_reg      <= tgt;
                resp_reg_data_reg <= (tgt == T_FLAG) ? flag_reg : result_reg;
                if (data_we_i && tgt == T_FLAG) begin
                    flag_reg <= flag_merged;
                end
                if (data_we_i && tgt == T_RESULT) begin
                    result_reg <= result_merged;
                end
            end
        end
    end

    // RAM contents survive reset, so this array has no reset branch.
    always_ff @(posedge clk_i) begin
        if (gnt && tgt == T_RAM) begin
            if (data_we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (data_be_i[b]) begin
                        ram_mem[ram_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
                    end
                end
            end else begin
                ram_rdata_reg <= ram_mem[ram_idx];
            end
        end
    end

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = (state_reg == S_RESP);
    assign data_err_o    = data_rvalid_o && (resp_tgt_reg == T_ERR);
    assign mem_flag_o    = flag_reg;
    assign mem_result_o  = result_reg;

    always_comb begin
        data_rdata_o = 32'd0;
        if (data_rvalid_o && !resp_we_reg) begin
            case (resp_tgt_reg)
                T_RAM:    data_rdata_o = ram_rdata_reg;
                T_FLAG:   data_rdata_o = resp_reg_data_reg;
                T_RESULT: data_rdata_o = resp_reg_data_reg;
                default:  data_rdata_o = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (0, 2 and 3 wait states) checked every
// cycle against an address-map model, plus literal expectations from hand calculation.
module tb_data_mem_responder;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req   [N];
    logic        we    [N];
    logic [3:0]  be    [N];
    logic [31:0] addr  [N];
    logic [31:0] wdata [N];
    logic        gnt   [N];
    logic        rvalid[N];
    logic        err   [N];
    logic [31:0] rdata [N];
    logic [31:0] flag  [N];
    logic [31:0] result[N];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_dut
            data_mem_responder #(
                .MEM_WORDS  (256),
                .WAIT_CYCLES(gi == 0 ? 0 : (gi == 1 ? 2 : 3)),
                .FLAG_ADDR  (32'h0000_0400),
                .RESULT_ADDR(32'h0000_0404)
            ) u_dut (
                .clk_i        (clk),
                .rst_ni       (rst_n),
                .data_req_i   (req[gi]),
                .data_gnt_o   (gnt[gi]),
                .data_rvalid_o(rvalid[gi]),
                .data_we_i    (we[gi]),
                .data_be_i    (be[gi]),
                .data_addr_i  (addr[gi]),
                .data_wdata_i (wdata[gi]),
                .data_rdata_o (rdata[gi]),
                .data_err_o   (err[gi]),
                .mem_flag_o   (flag[gi]),
                .mem_result_o (result[gi])
            );
        end
    endgenerate

    // Model state: what each instance's memory map must hold.
    logic [31:0] m_mem    [N][256];
    bit          m_known  [N][256];
    logic [31:0] m_flag   [N];
    logic [31:0] m_result [N];
    bit          exp_v    [N];
    bit          exp_err  [N];
    bit          exp_chk  [N];
    logic [31:0] exp_rdata[N];
    logic [31:0] last_rdata[N];
    bit          last_err [N];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit run   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int i, input logic [31:0] act,
                         input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s[%0d] @cyc %0d: got %h, expected %h", nm, i, cyc, act, expv);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++) if (b[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    // Apply one granted access to the model and queue the response expected next cycle.
    task automatic model_apply(input int i, input bit w, input logic [3:0] b,
                               input logic [31:0] a, input logic [31:0] d);
        int idx;
        exp_err[i]   = 1'b0;
        exp_chk[i]   = 1'b1;
        exp_rdata[i] = 32'd0;
        if (a < 32'd1024) begin
            idx = int'(a[9:2]);
            if (w) begin
                m_mem[i][idx]   = merge(m_mem[i][idx], d, b);
                m_known[i][idx] = m_known[i][idx] || (b == 4'hF);
            end else begin
                exp_rdata[i] = m_mem[i][idx];
                exp_chk[i]   = m_known[i][idx];
            end
        end else if ((a & ~32'h3) == 32'h0000_0400) begin
            if (w) m_flag[i] = merge(m_flag[i], d, b);
            else   exp_rdata[i] = m_flag[i];
        end else if ((a & ~32'h3) == 32'h0000_0404) begin
            if (w) m_result[i] = merge(m_result[i], d, b);
            else   exp_rdata[i] = m_result[i];
        end else begin
            exp_err[i] = 1'b1;
        end
        exp_v[i] = 1'b1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_flag[i]   = 32'd0;
            m_result[i] = 32'd0;
            exp_v[i]    = 1'b0;
        end
    endtask

    // Compare process: registered outputs checked just after every rising edge.
    always begin
        @(posedge clk);
        #1;
        if (run) begin
            for (int i = 0; i < N; i++) begin
                if (exp_v[i]) begin
                    check("rvalid", i, 32'(rvalid[i]), 32'd1);
                    check("err", i, 32'(err[i]), 32'(exp_err[i]));
                    if (exp_chk[i]) check("rdata", i, rdata[i], exp_rdata[i]);
                    last_rdata[i] = rdata[i];
                    last_err[i]   = err[i];
                    exp_v[i]      = 1'b0;
                end else begin
                    check("rvalid_idle", i, 32'(rvalid[i]), 32'd0);
                end
                check("flag", i, flag[i], m_flag[i]);
                check("result", i, result[i], m_result[i]);
            end
        end
    end

    // One transaction, started on a falling edge; returns on the falling edge of the RESP cycle.
    task automatic access(input int i, input bit w, input logic [3:0] b, input logic [31:0] a,
                          input logic [31:0] d, input int exp_lat, input bit hold);
        int start;
        start    = cyc;
        req[i]   = 1'b1;
        we[i]    = w;
        be[i]    = b;
        addr[i]  = a;
        wdata[i] = d;
        for (int k = 0; ; k++) begin
            #1;
            if (gnt[i]) break;
            if (k >= 40) begin
                check("gnt_timeout", i, 32'(k), 32'(exp_lat));
                req[i] = 1'b0;
                return;
            end
            @(negedge clk);
        end
        if (exp_lat >= 0) check("gnt_latency", i, 32'(cyc - start), 32'(exp_lat));
        model_apply(i, w, b, a, d);
        @(negedge clk);
        if (!hold) req[i] = 1'b0;
        $display("[TB] inst%0d %s be=%b addr=%h wdata=%h rdata=%h err=%0d", i,
                 w ? "store" : "load ", b, a, d, rdata[i], err[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            req[i] = 0; we[i] = 0; be[i] = 0; addr[i] = 0; wdata[i] = 0;
            last_rdata[i] = 0; last_err[i] = 0;
            for (int w = 0; w < 256; w++) m_known[i][w] = 1'b0;
        end
        model_reset();
        idle(3);
        for (int i = 0; i < N; i++) begin
            check("rst_rvalid", i, 32'(rvalid[i]), 32'd0);
            check("rst_gnt", i, 32'(gnt[i]), 32'd0);
            check("rst_err", i, 32'(err[i]), 32'd0);
            check("rst_rdata", i, rdata[i], 32'd0);
            check("rst_flag", i, flag[i], 32'd0);
            check("rst_result", i, result[i], 32'd0);
        end
        rst_n = 1'b1;
        run   = 1'b1;
        idle(2);

        // Zero wait states: RESULT then FLAG.
        access(0, 1, 4'hF, 32'h0000_0404, 32'd55, 0, 0);
        check("t1_result_lit", 0, result[0], 32'd55);
        idle(1);
        access(0, 1, 4'hF, 32'h0000_0400, 32'd1, 0, 0);
        check("t1_flag_lit", 0, flag[0], 32'd1);
        idle(1);

        // Partial store then load with a narrow be (read data must not be masked).
        access(0, 1, 4'hF, 32'h0000_000C, 32'd0, 0, 0);
        idle(1);
        access(0, 1, 4'b0101, 32'h0000_000C, 32'hAABB_CCDD, 0, 0);
        idle(1);
        access(0, 0, 4'b0001, 32'h0000_000C, 32'd0, 0, 0);
        check("t2_rdata_lit", 0, last_rdata[0], 32'h00BB_00DD);
        check("t2_err_lit", 0, 32'(last_err[0]), 32'd0);
        idle(1);

        // Back-to-back with req held: second gnt waits out the RESP cycle.
        access(0, 1, 4'hF, 32'h0000_0010, 32'h1111_1111, 0, 1);
        access(0, 1, 4'hF, 32'h0000_0014, 32'h2222_2222, 1, 0);
        idle(1);
        access(0, 1, 4'h0, 32'h0000_0010, 32'hFFFF_FFFF, 0, 0);
        idle(1);
        access(0, 0, 4'hF, 32'h0000_0010, 32'd0, 0, 1);
        check("t5_noop_lit", 0, last_rdata[0], 32'h1111_1111);
        access(0, 0, 4'hF, 32'h0000_0014, 32'd0, 1, 0);
        idle(1);
        access(0, 0, 4'hF, 32'h0000_0400, 32'd0, 0, 0);
        idle(1);

        // Error target: no RAM aliasing, registers untouched.
        access(0, 1, 4'hF, 32'h0000_0000, 32'h1234_5678, 0, 0);
        idle(1);
        access(0, 0, 4'hF, 32'h0000_0800, 32'd0, 0, 0);
        check("t4_err_lit", 0, 32'(last_err[0]), 32'd1);
        check("t4_rdata_lit", 0, last_rdata[0], 32'd0);
        idle(1);
        access(0, 1, 4'hF, 32'h0000_0800, 32'hDEAD_BEEF, 0, 0);
        idle(1);
        access(0, 0, 4'hF, 32'h0000_0000, 32'd0, 0, 0);
        check("t4_alias_lit", 0, last_rdata[0], 32'h1234_5678);
        idle(1);

        // Two wait states.
        access(1, 1, 4'hF, 32'h0000_0000, 32'hCAFE_F00D, 2, 0);
        idle(1);
        access(1, 0, 4'hF, 32'h0000_0000, 32'd0, 2, 0);
        check("t3_rdata_lit", 1, last_rdata[1], 32'hCAFE_F00D);
        idle(1);

        // Three wait states, request abandoned after one cycle.
        req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h0000_0400; wdata[2] = 32'd9;
        #1 check("t6_gnt_drop", 2, 32'(gnt[2]), 32'd0);
        @(negedge clk);
        req[2] = 1'b0;
        for (int k = 0; k < 6; k++) begin
            #1 check("t6_gnt_drop", 2, 32'(gnt[2]), 32'd0);
            @(negedge clk);
        end
        access(2, 1, 4'hF, 32'h0000_0400, 32'd7, 3, 0);
        check("t6_flag_lit", 2, flag[2], 32'd7);
        idle(1);

        // Reset during RESP of a RAM store: response aborted, store kept, registers cleared.
        access(2, 1, 4'hF, 32'h0000_0018, 32'h600D_600D, 3, 0);
        rst_n = 1'b0;
        run   = 1'b0;
        model_reset();
        #1;
        check("t6_rst_rvalid", 2, 32'(rvalid[2]), 32'd0);
        check("t6_rst_flag", 2, flag[2], 32'd0);
        check("t6_rst_flag", 0, flag[0], 32'd0);
        check("t6_rst_result", 0, result[0], 32'd0);
        idle(2);
        rst_n = 1'b1;
        run   = 1'b1;
        idle(1);
        access(2, 0, 4'hF, 32'h0000_0018, 32'd0, 3, 0);
        check("t6_keep_lit", 2, last_rdata[2], 32'h600D_600D);
        idle(3);

        run = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
